// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU (AND/OR/ADD/MUL) between NUM_REQ requesters.
// Define ALU_ARB_FLAGS_EN to add the res_ovf overflow/carry output.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_data,
    output logic [IDW-1:0]       res_id,
`ifdef ALU_ARB_FLAGS_EN
    output logic                 res_ovf,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg;
    logic [IDW-1:0]       ptr_reg;
    logic [3:0]           op_a_reg;
    logic [3:0]           op_b_reg;
    logic [1:0]           op_sel_reg;
    logic [IDW-1:0]       op_id_reg;
    logic [NUM_REQ-1:0]   gnt_reg;
    logic                 res_valid_reg;
    logic [3:0]           res_data_reg;
    logic [IDW-1:0]       res_id_reg;
    logic                 busy_reg;
`ifdef ALU_ARB_FLAGS_EN
    logic                 res_ovf_reg;
`endif

    logic [3:0]           a_arr   [NUM_REQ];
    logic [3:0]           b_arr   [NUM_REQ];
    logic [1:0]           sel_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   upper_mask;
    logic [NUM_REQ-1:0]   cand;
    logic [IDW-1:0]       win_id;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDW-1:0]       ptr_next;
    logic [31:0]          ptr_wide;

    assign ptr_wide = 32'(ptr_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign a_arr[gi]      = req_a[4*gi +: 4];
            assign b_arr[gi]      = req_b[4*gi +: 4];
            assign sel_arr[gi]    = req_sel[2*gi +: 2];
            assign upper_mask[gi] = (32'(gi) >= ptr_wide);
        end
    endgenerate

    // Requests at or above ptr take priority; otherwise wrap around to the lowest index.
    assign cand = (|(req & upper_mask)) ? (req & upper_mask) : req;

    always_comb begin
        win_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_id;
    assign ptr_next   = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    logic [3:0] alu_res;
`ifdef ALU_ARB_FLAGS_EN
    logic       alu_ovf;
    logic [4:0] sum_w;
    logic [7:0] prod_w;
    assign sum_w  = {1'b0, op_a_reg} + {1'b0, op_b_reg};
    assign prod_w = {4'b0, op_a_reg} * {4'b0, op_b_reg};
`else
    logic [3:0] sum_w;
    logic [3:0] prod_w;
    assign sum_w  = op_a_reg + op_b_reg;
    assign prod_w = op_a_reg * op_b_reg;
`endif

    always_comb begin
        alu_res = '0;
`ifdef ALU_ARB_FLAGS_EN
        alu_ovf = 1'b0;
`endif
        case (op_sel_reg)
            2'b00: alu_res = op_a_reg & op_b_reg;
            2'b01: alu_res = op_a_reg | op_b_reg;
            2'b10: begin
                alu_res = sum_w[3:0];
`ifdef ALU_ARB_FLAGS_EN
                alu_ovf = sum_w[4];
`endif
            end
            default: begin
                alu_res = prod_w[3:0];
`ifdef ALU_ARB_FLAGS_EN
                alu_ovf = |prod_w[7:4];
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_sel_reg    <= '0;
            op_id_reg     <= '0;
            gnt_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
            busy_reg      <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            res_ovf_reg   <= 1'b0;
`endif
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        op_a_reg   <= a_arr[win_id];
                        op_b_reg   <= b_arr[win_id];
                        op_sel_reg <= sel_arr[win_id];
                        op_id_reg  <= win_id;
                        gnt_reg    <= win_onehot;
                        ptr_reg    <= ptr_next;
                        busy_reg   <= 1'b1;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_reg  <= alu_res;
                    res_id_reg    <= op_id_reg;
                    res_valid_reg <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
                    res_ovf_reg   <= alu_ovf;
`endif
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign busy      = busy_reg;
`ifdef ALU_ARB_FLAGS_EN
    assign res_ovf   = res_ovf_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: single op, round-robin order, backpressure,
// per-op truncation and asynchronous reset mid-operation.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_sel;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        busy;
`ifdef ALU_ARB_FLAGS_EN
    logic        res_ovf;
`endif

    int tests_run;
    int tests_failed;

    alu_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
`ifdef ALU_ARB_FLAGS_EN
        .res_ovf   (res_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; drives one full transaction and leaves req low.
    task automatic issue(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                         input logic [3:0] exp_data, input logic [1:0] exp_id, input logic exp_ovf);
        req = r;
        @(negedge clk);
        chk({tag, ".gnt"}, gnt, exp_gnt);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".valid_early"}, res_valid, 0);
        req = r & ~exp_gnt;
        @(negedge clk);
        chk({tag, ".gnt_pulse"}, gnt, 0);
        chk({tag, ".valid"}, res_valid, 1);
        chk({tag, ".data"}, res_data, exp_data);
        chk({tag, ".id"}, res_id, exp_id);
`ifdef ALU_ARB_FLAGS_EN
        chk({tag, ".ovf"}, res_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("[TB] %s unexpected x flag", tag);
`endif
        res_ready = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk({tag, ".valid_clr"}, res_valid, 0);
        chk({tag, ".busy_clr"}, busy, 0);
        res_ready = 1'b0;
        $display("[TB] %s req=%b gnt=%b data=%h id=%0d", tag, r, exp_gnt, exp_data, exp_id);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        res_ready = 1'b0;
        // r0: 3+5=8, r1: 4+2=6, r2: 7|3=7, r3: 6*3=18 -> 2 (ovf)
        req_a   = {4'h6, 4'h7, 4'h4, 4'h3};
        req_b   = {4'h3, 4'h3, 4'h2, 4'h5};
        req_sel = {2'b11, 2'b01, 2'b10, 2'b10};

        repeat (2) @(negedge clk);
        chk("rst.gnt", gnt, 0);
        chk("rst.valid", res_valid, 0);
        chk("rst.data", res_data, 0);
        chk("rst.id", res_id, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.no_req_busy", busy, 0);
        chk("idle.no_req_gnt", gnt, 0);

        issue("single", 4'b0001, 4'b0001, 4'h8, 2'd0, 1'b0);

        // ptr is now 1
        issue("rr1", 4'b1111, 4'b0010, 4'h6, 2'd1, 1'b0);
        issue("rr2", 4'b1101, 4'b0100, 4'h7, 2'd2, 1'b0);
        issue("rr3", 4'b1001, 4'b1000, 4'h2, 2'd3, 1'b1);
        issue("rr0", 4'b0001, 4'b0001, 4'h8, 2'd0, 1'b0);
        issue("rr_p1", 4'b0010, 4'b0010, 4'h6, 2'd1, 1'b0);
        issue("rr_p2", 4'b1001, 4'b1000, 4'h2, 2'd3, 1'b1);
        issue("rr_wrap", 4'b1111, 4'b0001, 4'h8, 2'd0, 1'b0);

        // Backpressure: ptr=1, only r0 requests -> wraps to r0
        req = 4'b0001;
        @(negedge clk);
        chk("bp.gnt", gnt, 4'b0001);
        req = 4'b0000;
        req_a[3:0] = 4'hF;
        @(negedge clk);
        chk("bp.valid", res_valid, 1);
        req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.hold_valid", res_valid, 1);
            chk("bp.hold_data", res_data, 4'h8);
            chk("bp.hold_id", res_id, 0);
            chk("bp.hold_gnt", gnt, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp.accept_valid", res_valid, 0);
        chk("bp.accept_gnt", gnt, 0);
        @(negedge clk);
        chk("bp.next_gnt", gnt, 4'b0010);
        req = 4'b0000;
        @(negedge clk);
        chk("bp.next_data", res_data, 4'h6);
        chk("bp.next_id", res_id, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        req_a[3:0] = 4'h3;
        $display("[TB] backpressure hold 5 cycles then grant r1");

        // Truncation on requester 2 with a=b=F
        req_a[11:8] = 4'hF;
        req_b[11:8] = 4'hF;
        req_sel[5:4] = 2'b00;
        issue("trunc_and", 4'b0100, 4'b0100, 4'hF, 2'd2, 1'b0);
        req_sel[5:4] = 2'b01;
        issue("trunc_or", 4'b0100, 4'b0100, 4'hF, 2'd2, 1'b0);
        req_sel[5:4] = 2'b10;
        issue("trunc_add", 4'b0100, 4'b0100, 4'hE, 2'd2, 1'b1);
        req_sel[5:4] = 2'b11;
        issue("trunc_mul", 4'b0100, 4'b0100, 4'h1, 2'd2, 1'b1);

        // Reset mid-operation: ptr is 3 here, reset must bring it back to 0
        req = 4'b0100;
        @(negedge clk);
        chk("mid.gnt_before", gnt, 4'b0100);
        req = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("mid.gnt_async", gnt, 0);
        chk("mid.valid_async", res_valid, 0);
        chk("mid.busy_async", busy, 0);
        @(negedge clk);
        chk("mid.valid_hold", res_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.idle_busy", busy, 0);
        issue("post_rst", 4'b1111, 4'b0001, 4'h8, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
